// File: rtl/aes_inv_round_ctrl_if.sv
// Block-stream interface for the AES inverse-cipher sequencer.
// Carries the ciphertext input handshake and the plaintext output handshake.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface aes_inv_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;

  modport slave (
    input  in_valid, ct_in, out_ready,
    output in_ready, out_valid, pt_out
  );

  modport master (
    output in_valid, ct_in, out_ready,
    input  in_ready, out_valid, pt_out
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer.
// Holds the 128-bit state and runs it NR times through an external combinational
// inverse-round datapath, indexing the round-key store as it goes.
// Optional feature: define AES_INV_CTRL_ABORT_EN to add an abort input that
// drops an in-flight block and returns to IDLE.
module aes_inv_round_ctrl #(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef AES_INV_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  aes_inv_round_ctrl_if.slave  io,
  output logic [RKW-1:0]       rk_idx,
  input  logic [127:0]         rk,
  output logic [127:0]         dp_state,
  output logic                 dp_last,
  input  logic [127:0]         dp_result,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Key index of the initial AddRoundKey and of the first full inverse round.
  localparam logic [RKW-1:0] RK_INIT  = RKW'(NR);
  localparam logic [RKW-1:0] RK_FIRST = RKW'(NR - 1);

  logic [2:0]     fsm;
  logic [127:0]   state_q;
  logic [RKW-1:0] cnt;
  logic           abort_req;

`ifdef AES_INV_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Sequencer: accept a block, whiten it with the last round key, iterate the
  // inverse rounds down to key 0, then hold the plaintext until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm     <= S_IDLE;
      state_q <= '0;
      cnt     <= '0;
    end else if (abort_req && (fsm != S_IDLE)) begin
      fsm     <= S_IDLE;
      state_q <= '0;
      cnt     <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (io.in_valid) begin
            state_q <= io.ct_in;
            cnt     <= RK_FIRST;
            fsm     <= S_INIT;
          end
        end
        S_INIT: begin
          state_q <= state_q ^ rk;
          fsm     <= S_ROUND;
        end
        S_ROUND: begin
          state_q <= dp_result;
          // cnt parks at 1 on the last full round so it never underflows.
          if (cnt == RKW'(1)) begin
            fsm <= S_FINAL;
          end else begin
            cnt <= cnt - RKW'(1);
          end
        end
        S_FINAL: begin
          state_q <= dp_result;
          fsm     <= S_DONE;
        end
        S_DONE: begin
          if (io.out_ready) begin
            fsm <= S_IDLE;
          end
        end
        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: handshakes, key index and datapath control follow the state only.
  always_comb begin
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.pt_out    = '0;
    rk_idx       = RK_INIT;
    dp_last      = 1'b0;
    busy         = (fsm != S_IDLE);
    dp_state     = state_q;
    case (fsm)
      S_IDLE:  io.in_ready = 1'b1;
      S_INIT:  rk_idx      = RK_INIT;
      S_ROUND: rk_idx      = cnt;
      S_FINAL: begin
        rk_idx  = '0;
        dp_last = 1'b1;
      end
      S_DONE: begin
        io.out_valid = 1'b1;
        io.pt_out    = state_q;
      end
      default: rk_idx = RK_INIT;
    endcase
  end

endmodule
